// File: rtl/io_switch_debounce.sv
// Switch input conditioner: 2-flop synchroniser, shared tick prescaler, per-channel debounce FSM,
// registered clean level with rise/fall pulses. Define SW_EDGE_LATCH_EN to add sticky rise flags.
module io_switch_debounce #(
  parameter int N            = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_clean,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic [N-1:0] sw_pend,
  input  logic [N-1:0] pend_clr
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_TICKS);

  typedef enum logic [1:0] {
    S_LO      = 2'd0,
    S_HI_WAIT = 2'd1,
    S_HI      = 2'd2,
    S_LO_WAIT = 2'd3
  } state_e;

  logic [N-1:0]     sync1_q, sync1_d;
  logic [N-1:0]     sync2_q, sync2_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  state_e           state_q [N];
  state_e           state_d [N];
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     clean_q, clean_d;
  logic [N-1:0]     rise_q, rise_d;
  logic [N-1:0]     fall_q, fall_d;

  // Synchroniser and prescaler
  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    tick    = (pre_q == PRE_LAST);
    pre_d   = tick ? '0 : pre_q + 1'b1;
  end

  // Per-channel debounce; a level change during WAIT falls back without touching the output
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_LO: begin
          if (sync2_q[i]) begin
            state_d[i] = S_HI_WAIT;
            cnt_d[i]   = '0;
          end
        end
        S_HI_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_LO;
          end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) state_d[i] = S_HI;
            if (cnt_q[i] != CNT_MAX)  cnt_d[i]   = cnt_q[i] + 1'b1;
          end
        end
        S_HI: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_LO_WAIT;
            cnt_d[i]   = '0;
          end
        end
        S_LO_WAIT: begin
          if (sync2_q[i]) begin
            state_d[i] = S_HI;
          end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) state_d[i] = S_LO;
            if (cnt_q[i] != CNT_MAX)  cnt_d[i]   = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = S_LO;
      endcase
      clean_d[i] = (state_d[i] == S_HI) || (state_d[i] == S_LO_WAIT);
      rise_d[i]  = (state_q[i] == S_HI_WAIT) && (state_d[i] == S_HI);
      fall_d[i]  = (state_q[i] == S_LO_WAIT) && (state_d[i] == S_LO);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pre_q   <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= S_LO;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pre_q   <= pre_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

`ifdef SW_EDGE_LATCH_EN
  logic [N-1:0] pend_q, pend_d;

  // Set has priority over a simultaneous software clear
  always_comb pend_d = rise_q | (pend_q & ~pend_clr);

  always_ff @(posedge clk) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign sw_pend = pend_q;
`else
  logic unused_pend_clr;
  assign unused_pend_clr = ^pend_clr;
  assign sw_pend         = '0;
`endif

endmodule
